// File: rtl/instr_fetch.sv
// Instruction fetch stage: 8-bit fetch PC, 1-cycle memory, 2-entry buffer.
// Ports: clk, rst (async, active-high); imem_req/imem_addr/imem_rdata to
// instruction memory; redirect_valid/redirect_pc from datapath; if_valid/
// if_ready handshake with if_instr/if_pc/if_opcode; halted status.
// Optional IF_HALT_EN: opcode 6'h3F stops fetching until redirect or reset.
module instr_fetch (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [7:0]  if_pc,
  output logic [5:0]  if_opcode,
  output logic        halted
);

  localparam logic [5:0] HALT_OP = 6'h3F;

  logic [7:0]  fetch_pc;
  logic [7:0]  resp_pc;
  logic        inflight;
  logic [31:0] q_instr [2];
  logic [7:0]  q_pc [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [1:0]  occ;
  logic        pop;
  logic        push;
  logic        halt_q;
  logic        halt_hit;

  assign pop  = if_valid && if_ready;
  assign push = inflight && !redirect_valid && !halt_q;

  // Occupancy after this cycle's pop plus the response still in flight;
  // count + inflight never exceeds 2, so two bits suffice.
  assign occ = count - {1'b0, pop} + {1'b0, inflight};

`ifdef IF_HALT_EN
  // Halt word arriving now: suppress a request in the same cycle.
  assign halt_hit = inflight && !halt_q &&
                    (imem_rdata[31:26] == HALT_OP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      halt_q <= 1'b0;
    else if (redirect_valid)
      halt_q <= 1'b0;
    else if (halt_hit)
      halt_q <= 1'b1;
  end
`else
  assign halt_hit = 1'b0;
  assign halt_q   = 1'b0;
`endif

  assign halted = halt_q;

  // Gated by rst so nothing is requested while reset is held.
  assign imem_req = !rst && !redirect_valid && !halt_q &&
                    !halt_hit && (occ < 2'd2);
  assign imem_addr = fetch_pc;

  assign if_valid  = (count != 2'd0);
  assign if_instr  = q_instr[rd_ptr];
  assign if_pc     = q_pc[rd_ptr];
  assign if_opcode = if_instr[31:26];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc   <= 8'h00;
      resp_pc    <= 8'h00;
      inflight   <= 1'b0;
      q_instr[0] <= '0;
      q_instr[1] <= '0;
      q_pc[0]    <= '0;
      q_pc[1]    <= '0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      count      <= 2'd0;
    end else if (redirect_valid) begin
      // Any handshake this cycle is consumed; the flush empties the rest.
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc <= fetch_pc + 8'd4;
        resp_pc  <= fetch_pc;
      end
      if (push) begin
        q_instr[wr_ptr] <= imem_rdata;
        q_pc[wr_ptr]    <= resp_pc;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: random ready/redirect traffic
// against a stream-level model of the fetched instruction sequence.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [7:0]  if_pc;
  logic [5:0]  if_opcode;
  logic        halted;

  instr_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .if_opcode(if_opcode),
    .halted(halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [31:0] rom [64];

  // Stream model: deliveries are consecutive words from the last
  // reset/redirect target; a word can be taken two cycles after its request.
  int          issued;
  int          deliv;
  bit          prev_req;
  bit          halt_pend;
  logic [7:0]  exp_pc;
  logic [7:0]  exp_addr;
  bit          last_stall;
  logic [7:0]  last_pc;
  logic [31:0] last_instr;
  bit          req_s;
  logic [7:0]  addr_s;

  logic        s_valid;
  logic [7:0]  s_pc;
  logic [31:0] s_instr;
  logic        s_req;
  logic [7:0]  s_addr;
  logic        s_halted;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    issued = 0; deliv = 0; prev_req = 0; halt_pend = 0;
    exp_pc = 8'h00; exp_addr = 8'h00; last_stall = 0;
    req_s = 0; addr_s = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_ready = 1'b0; redirect_valid = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", if_valid, 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_opcode", if_opcode, 0);
    chk("rst_halted", halted, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    imem_rdata = $urandom;
  endtask

  task automatic cycle(input bit rdy, input bit rv, input logic [7:0] rpc);
    int avail;
    if_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
    @(negedge clk);
    s_valid = if_valid; s_pc = if_pc; s_instr = if_instr;
    s_req = imem_req; s_addr = imem_addr; s_halted = halted;
    avail = issued - (prev_req ? 1 : 0) - deliv;
    chk("valid", if_valid, (avail > 0) ? 1 : 0);
    if (last_stall && if_valid) begin
      chk("hold_pc", if_pc, last_pc);
      chk("hold_instr", if_instr, last_instr);
    end
    if (if_valid) begin
      chk("head_pc", if_pc, exp_pc);
      chk("head_instr", if_instr, rom[exp_pc[7:2]]);
      chk("head_opcode", if_opcode, rom[exp_pc[7:2]][31:26]);
    end
    if (if_valid && rdy) begin
      deliv++;
      exp_pc = exp_pc + 8'd4;
    end
    last_stall = if_valid && !rdy;
    last_pc = if_pc; last_instr = if_instr;
    if (rv) chk("redir_req", imem_req, 0);
    else if (imem_req) chk("req_addr", imem_addr, exp_addr);
    if (halt_pend) chk("halt_noreq", imem_req, 0);
`ifndef IF_HALT_EN
    chk("halted_zero", halted, 0);
`endif
    chk("occupancy", ((issued - deliv + (imem_req ? 1 : 0)) <= 2) ? 1 : 0, 1);
    if (imem_req) begin
      issued++;
`ifdef IF_HALT_EN
      if (rom[imem_addr[7:2]][31:26] == 6'h3F) halt_pend = 1;
`endif
      exp_addr = exp_addr + 8'd4;
    end
    prev_req = imem_req;
    req_s = imem_req; addr_s = imem_addr;
    if (rv) begin
      exp_pc = rpc; exp_addr = rpc;
      issued = 0; deliv = 0; prev_req = 0;
      halt_pend = 0; last_stall = 0;
    end
    @(posedge clk); #1;
    imem_rdata = req_s ? rom[addr_s[7:2]] : $urandom;
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  prev_d;
    logic [7:0]  last_d;
    bit          saw_wrap;
    bit          got;
    int          nreq;

    for (int k = 0; k < 64; k++) begin
      w = $urandom;
      if (w[31:26] == 6'h3F) w[31:26] = 6'h00;
      rom[k] = (k < 4) ? k : w;
    end
    model_reset();
    #2;
    do_reset();

    // Start-up latency and back-to-back delivery.
    for (int c = 0; c < 5; c++) begin
      cycle(1, 0, 8'h00);
      if (c == 0) begin
        chk("first_req", s_req, 1);
        chk("first_addr", s_addr, 8'h00);
      end
      if (c < 2) chk("early_valid", s_valid, 0);
      if (c >= 2) begin
        chk("seq_valid", s_valid, 1);
        chk("seq_pc", s_pc, 8'((c - 2) * 4));
        chk("seq_instr", s_instr, c - 2);
      end
    end

    // Back-pressure from reset: head held at 0x00, only 2 fetched.
    do_reset();
    nreq = 0;
    for (int c = 0; c < 7; c++) begin
      cycle(0, 0, 8'h00);
      nreq += s_req;
    end
    chk("stall_pc", s_pc, 8'h00);
    chk("stall_valid", s_valid, 1);
    chk("stall_reqs", nreq, 2);
    for (int c = 0; c < 6; c++) cycle(1, 0, 8'h00);

    // Redirect with a full buffer.
    for (int c = 0; c < 3; c++) cycle(0, 0, 8'h00);
    chk("full_valid", s_valid, 1);
    cycle(0, 1, 8'h40);
    cycle(1, 0, 8'h00);
    chk("redir_flush", s_valid, 0);
    got = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1, 0, 8'h00);
      if (s_valid && !got) begin
        chk("redir_first_pc", s_pc, 8'h40);
        got = 1;
      end
    end
    chk("redir_delivered", got, 1);

    // Wrap of the fetch PC from 0xFC to 0x00.
    cycle(1, 1, 8'hF0);
    saw_wrap = 0; prev_d = 8'h00;
    for (int c = 0; c < 10; c++) begin
      cycle(1, 0, 8'h00);
      if (s_valid) begin
        if (prev_d == 8'hFC && s_pc == 8'h00) saw_wrap = 1;
        prev_d = s_pc;
      end
    end
    chk("wrap_seen", saw_wrap, 1);

    // Random ready and redirect traffic.
    for (int c = 0; c < 400; c++) begin
      cycle(($urandom % 4) != 0, ($urandom % 16) == 0,
            {6'($urandom_range(0, 63)), 2'b00});
    end

    // Reset mid-stream with a request in flight.
    for (int c = 0; c < 3; c++) cycle(1, 0, 8'h00);
    chk("pre_rst_req", s_req, 1);
    do_reset();
    got = 0;
    for (int c = 0; c < 4; c++) begin
      cycle(1, 0, 8'h00);
      if (s_valid && !got) begin
        chk("post_rst_pc", s_pc, 8'h00);
        got = 1;
      end
    end
    chk("post_rst_deliv", got, 1);

    // Halt opcode at 0x10.
    rst = 1'b1;
    #1;
    rom[4] = {6'h3F, 26'h0123456};
    do_reset();
    last_d = 8'h00;
    for (int c = 0; c < 14; c++) begin
      cycle(1, 0, 8'h00);
      if (s_valid) last_d = s_pc;
    end
`ifdef IF_HALT_EN
    chk("halt_set", s_halted, 1);
    chk("halt_last_pc", last_d, 8'h10);
    chk("halt_req", s_req, 0);
    cycle(1, 1, 8'h00);
    cycle(1, 0, 8'h00);
    chk("halt_clear", s_halted, 0);
    chk("halt_restart", s_req, 1);
    rst = 1'b1;
    #1;
`else
    chk("nohalt_flag", s_halted, 0);
    chk("nohalt_past", (last_d > 8'h10) ? 1 : 0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
